pipe_stage_skid_reg: RTL and testbench

//  Parametrised elastic pipeline-stage register for the pipelined CPU (MEM->WB and similar boundaries).

---
 rtl/pipe_stage_skid_reg_if.sv | 47 ++++
 rtl/pipe_stage_skid_reg.sv | 143 ++++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_reg_if.sv
// pipe_stage_skid_reg_if
//   Handshake and payload bundle for pipe_stage_skid_reg.
//   master : upstream/downstream driver side (drives in_*, out_ready, flush)
//   slave  : the pipeline stage itself
// Signals
//   flush                          squash all held entries
//   in_valid / in_ready            upstream handshake
//   in_wreg, in_m2reg, in_mo,
//   in_alu, in_rn                  upstream entry payload
//   out_valid / out_ready          downstream handshake
//   out_wreg, out_m2reg, out_mo,
//   out_alu, out_rn                presented entry payload
//   stall_cnt, flush_cnt           performance counters
interface pipe_stage_skid_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RN_W   = 5
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              in_wreg;
    logic              in_m2reg;
    logic [DATA_W-1:0] in_mo;
    logic [DATA_W-1:0] in_alu;
    logic [RN_W-1:0]   in_rn;
    logic              out_valid;
    logic              out_ready;
    logic              out_wreg;
    logic              out_m2reg;
    logic [DATA_W-1:0] out_mo;
    logic [DATA_W-1:0] out_alu;
    logic [RN_W-1:0]   out_rn;
    logic [31:0]       stall_cnt;
    logic [15:0]       flush_cnt;

    modport master (
        output flush, in_valid, in_wreg, in_m2reg, in_mo, in_alu, in_rn, out_ready,
        input  in_ready, out_valid, out_wreg, out_m2reg, out_mo, out_alu, out_rn,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  flush, in_valid, in_wreg, in_m2reg, in_mo, in_alu, in_rn, out_ready,
        output in_ready, out_valid, out_wreg, out_m2reg, out_mo, out_alu, out_rn,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg
//   Elastic pipeline-stage register (e.g. MEM->WB) with valid/ready handshake, a 2-entry
//   skid buffer (main + skid register) and a synchronous flush. in_ready is registered so
//   there is no combinational path from out_ready back upstream.
// Ports
//   clock  : single clock, posedge
//   reset  : synchronous active-high reset (dominates flush)
//   bus    : pipe_stage_skid_reg_if.slave (handshake, payload, flush, perf counters)
// Configuration
//   PIPE_STAGE_PERF_EN : when defined, stall_cnt/flush_cnt are saturating counters;
//                        otherwise they are tied to 0.
module pipe_stage_skid_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RN_W   = 5
) (
    input logic                  clock,
    input logic                  reset,
    pipe_stage_skid_reg_if.slave bus
);

    typedef struct packed {
        logic              wreg;
        logic              m2reg;
        logic [DATA_W-1:0] mo;
        logic [DATA_W-1:0] alu;
        logic [RN_W-1:0]   rn;
    } entry_t;

    // State encodes occupancy: main only drives outputs, skid catches the overflow entry.
    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e state_q, state_d;
    logic   in_ready_q, in_ready_d;
    entry_t main_q, skid_q, in_entry;
    logic   out_valid, acc, fire;
    logic   load_main_in, load_main_skid, load_skid;

    assign in_entry = '{wreg:  bus.in_wreg,
                        m2reg: bus.in_m2reg,
                        mo:    bus.in_mo,
                        alu:   bus.in_alu,
                        rn:    bus.in_rn};

    assign out_valid = (state_q != StEmpty);
    assign acc       = bus.in_valid & in_ready_q;
    assign fire      = out_valid & bus.out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (acc) begin
                    state_d      = StOne;
                    load_main_in = 1'b1;
                end
            end
            StOne: begin
                if (acc && fire) begin
                    load_main_in = 1'b1;
                end else if (acc) begin
                    state_d   = StTwo;
                    load_skid = 1'b1;
                end else if (fire) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                // in_ready is low here, so acc cannot occur.
                if (fire) begin
                    state_d        = StOne;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush drops everything, including an entry accepted this cycle; payload regs are
        // left untouched since outputs are gated by out_valid.
        if (bus.flush) begin
            state_d        = StEmpty;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
        in_ready_d = (state_d != StTwo);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            if (load_main_in) begin
                main_q <= in_entry;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.out_wreg  = main_q.wreg & out_valid;
    assign bus.out_m2reg = main_q.m2reg & out_valid;
    assign bus.out_mo    = main_q.mo;
    assign bus.out_alu   = main_q.alu;
    assign bus.out_rn    = main_q.rn;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (out_valid && !bus.out_ready && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (bus.flush && out_valid && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb_pipe_stage_skid_reg
//   Directed plus random stimulus against a queue-based reference model of a 2-deep FIFO
//   stage with flush and reset.
module tb_pipe_stage_skid_reg;

    localparam int unsigned DataW = 32;
    localparam int unsigned RnW   = 5;

`ifdef PIPE_STAGE_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    typedef struct {
        logic             wreg;
        logic             m2reg;
        logic [DataW-1:0] mo;
        logic [DataW-1:0] alu;
        logic [RnW-1:0]   rn;
    } ent_t;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    pipe_stage_skid_reg_if #(.DATA_W(DataW), .RN_W(RnW)) bus ();

    pipe_stage_skid_reg #(.DATA_W(DataW), .RN_W(RnW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: FIFO contents and counter totals.
    ent_t        q[$];
    longint      m_stall;
    longint      m_flush;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [DataW-1:0] alu, input logic rdy,
                         input logic fl);
        bus.in_valid  = v;
        bus.in_alu    = alu;
        bus.in_mo     = ~alu;
        bus.in_wreg   = alu[0];
        bus.in_m2reg  = alu[1];
        bus.in_rn     = alu[RnW-1:0] ^ RnW'(3);
        bus.out_ready = rdy;
        bus.flush     = fl;
    endtask

    task automatic check_outputs();
        logic [63:0] exp_stall;
        logic [63:0] exp_flush;
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            chk("out_wreg", 64'(bus.out_wreg), 64'(q[0].wreg));
            chk("out_m2reg", 64'(bus.out_m2reg), 64'(q[0].m2reg));
            chk("out_mo", 64'(bus.out_mo), 64'(q[0].mo));
            chk("out_alu", 64'(bus.out_alu), 64'(q[0].alu));
            chk("out_rn", 64'(bus.out_rn), 64'(q[0].rn));
        end else begin
            chk("out_wreg_idle", 64'(bus.out_wreg), 64'd0);
            chk("out_m2reg_idle", 64'(bus.out_m2reg), 64'd0);
        end
        exp_stall = PerfEn ? 64'(m_stall) : 64'd0;
        exp_flush = PerfEn ? 64'(m_flush) : 64'd0;
        chk("stall_cnt", 64'(bus.stall_cnt), exp_stall);
        chk("flush_cnt", 64'(bus.flush_cnt), exp_flush);
    endtask

    task automatic update_model();
        ent_t e;
        bit   acc;
        bit   fire;
        acc  = bus.in_valid && (q.size() < 2);
        fire = (q.size() > 0) && bus.out_ready;
        if (reset) begin
            q.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            if ((q.size() > 0) && !bus.out_ready && (m_stall < 64'hFFFF_FFFF)) m_stall++;
            if (bus.flush && (q.size() > 0) && (m_flush < 64'hFFFF)) m_flush++;
            if (bus.flush) begin
                q.delete();
            end else begin
                if (fire) void'(q.pop_front());
                if (acc) begin
                    e.wreg  = bus.in_wreg;
                    e.m2reg = bus.in_m2reg;
                    e.mo    = bus.in_mo;
                    e.alu   = bus.in_alu;
                    e.rn    = bus.in_rn;
                    q.push_back(e);
                end
            end
        end
    endtask

    // Inputs are set before calling; checks happen on the falling edge, then one rising edge.
    task automatic step();
        @(negedge clock);
        check_outputs();
        update_model();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_stall  = 0;
        m_flush  = 0;
        reset    = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);

        // 1. Reset for two cycles.
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_wreg", 64'(bus.out_wreg), 64'd0);
        chk("rst_out_alu", 64'(bus.out_alu), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // 2. Streaming at full rate: each word appears one cycle after it is offered.
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, DataW'(k), 1'b1, 1'b0);
            step();
            chk("stream_alu", 64'(bus.out_alu), 64'(k));
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();

        // 3. Fill both entries while blocked, then drain in order.
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        step();
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("drain_first", 64'(bus.out_alu), 64'hA);
        step();
        chk("drain_second", 64'(bus.out_alu), 64'hB);
        step();
        chk("drained_in_ready", 64'(bus.in_ready), 64'd1);

        // 4. Flush in the full state with a new entry offered: nothing survives.
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h13, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hC, 1'b1, 1'b1);
        step();
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_out_wreg", 64'(bus.out_wreg), 64'd0);
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (3) step();

        // 5. Hold one entry (wreg=1, rn=5) against backpressure for three cycles.
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        bus.in_wreg = 1'b1;
        bus.in_rn   = RnW'(5);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (3) begin
            step();
            chk("hold_rn", 64'(bus.out_rn), 64'd5);
            chk("hold_wreg", 64'(bus.out_wreg), 64'd1);
            chk("hold_alu", 64'(bus.out_alu), 64'h55);
        end
        chk("stall_cnt_3", 64'(bus.stall_cnt), PerfEn ? 64'd3 : 64'd0);

        // 6. Reset together with flush while full.
        drive(1'b1, 32'h66, 1'b0, 1'b0);
        step();
        chk("two_in_ready", 64'(bus.in_ready), 64'd0);
        reset = 1'b1;
        drive(1'b1, 32'h77, 1'b1, 1'b1);
        step();
        reset = 1'b0;
        chk("rst6_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst6_stall_cnt", 64'(bus.stall_cnt), 64'd0);
        chk("rst6_flush_cnt", 64'(bus.flush_cnt), 64'd0);
        chk("rst6_out_alu", 64'(bus.out_alu), 64'd0);
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (3) step();

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 3) != 0), DataW'($urandom), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 19) == 0));
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
